// File: rtl/video_in_dma_pkg.sv
// rtl/video_in_dma_pkg.sv - shared state type and frame sizing for the video input DMA
package video_in_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_DATA = 2'd1,
      ST_BURST     = 2'd2,
      ST_IRQ       = 2'd3
   } dma_state_t;

   // Words per frame for the default 640x480 geometry with four pixels per word
   localparam int unsigned DEF_WORDS_PER_FRAME = 640 * 480 / 4;

   // Words per frame for an arbitrary geometry; one word carries ppw pixels
   function automatic logic [31:0] words_per_frame(input int unsigned width,
                                                   input int unsigned height,
                                                   input int unsigned ppw);
      return 32'(width * height / ppw);
   endfunction

endpackage

// File: rtl/video_in_irq_stretch.sv
// rtl/video_in_irq_stretch.sv - stretches a one-cycle start into a P_IRQ_CYCLES irq pulse
module video_in_irq_stretch
#(
   parameter int P_IRQ_CYCLES = 3
)
(
   input  logic clk,
   input  logic nRST,
   input  logic start,
   output logic irq,
   output logic last
);

   localparam int CW = $clog2(P_IRQ_CYCLES + 1);

   logic [CW-1:0] cnt;

   // Load the pulse length on start, then count down to zero
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= CW'(P_IRQ_CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign irq  = (cnt != '0);
   assign last = (cnt == CW'(1));

endmodule

// File: rtl/video_in_dma.sv
// rtl/video_in_dma.sv - frame DMA from pixel FIFO to Wishbone memory; VIDEO_IN_DMA_ERR_EN enables bus error abort
module video_in_dma
   import video_in_dma_pkg::*;
#(
   parameter int P_WIDTH        = 640,
   parameter int P_HEIGHT       = 480,
   parameter int P_PIX_PER_WORD = 4,
   parameter int P_BURST        = 16,
   parameter int P_IRQ_CYCLES   = 3,
   parameter int P_FIFO_AW      = 6
)
(
   input  logic                 clk,
   input  logic                 nRST,
   input  logic [31:0]          cfg_addr,
   input  logic                 cfg_valid,
   input  logic [31:0]          fifo_data,
   input  logic [P_FIFO_AW:0]   fifo_level,
   output logic                 fifo_rd,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [3:0]           wb_sel_o,
   output logic [31:0]          wb_adr_o,
   output logic [31:0]          wb_dat_o,
   input  logic                 wb_ack_i,
   input  logic                 wb_err_i,
   output logic                 irq,
   output logic                 busy,
   output logic                 err
);

   localparam logic [31:0]          WPF       = words_per_frame(P_WIDTH, P_HEIGHT, P_PIX_PER_WORD);
   localparam logic [31:0]          LAST_BEAT = 32'(P_BURST - 1);
   localparam logic [P_FIFO_AW:0]   BURST_LVL = (P_FIFO_AW + 1)'(P_BURST);

   dma_state_t  state, state_nxt;
   logic        cfg_valid_q;
   logic        new_addr;
   logic        pending;
   logic [31:0] pending_addr;
   logic [31:0] base_addr;
   logic [31:0] word_idx;
   logic [31:0] beat_cnt;
   logic        in_burst;
   logic        err_hit;
   logic        ack_ok;
   logic        start_frame;
   logic        irq_start;
   logic        irq_last;
   logic        err_q;

   assign new_addr    = cfg_valid & ~cfg_valid_q;
   assign in_burst    = (state == ST_BURST);
   assign start_frame = (state == ST_IDLE) & (new_addr | pending);

`ifdef VIDEO_IN_DMA_ERR_EN
   assign err_hit = in_burst & wb_err_i;
   assign err     = err_q;
`else
   logic unused_err_i;
   assign unused_err_i = wb_err_i;
   assign err_hit      = 1'b0;
   assign err          = 1'b0;
`endif

   // An error on the same cycle as ack aborts the word, so it is never popped
   assign ack_ok  = in_burst & wb_ack_i & ~err_hit;
   assign fifo_rd = ack_ok & (fifo_level != '0);

   // Bus outputs derive from the state register so reset drops them immediately
   assign wb_cyc_o = in_burst;
   assign wb_stb_o = in_burst;
   assign wb_we_o  = in_burst;
   assign wb_sel_o = 4'hF;
   assign wb_adr_o = in_burst ? (base_addr + (word_idx << 2)) : 32'h0;
   assign wb_dat_o = in_burst ? fifo_data : 32'h0;
   assign busy     = (state == ST_WAIT_DATA) | in_burst;

   // State register
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and irq launch
   always_comb begin
      state_nxt = state;
      irq_start = 1'b0;
      case (state)
         ST_IDLE: begin
            if (new_addr | pending) begin
               state_nxt = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            if (fifo_level >= BURST_LVL) begin
               state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            if (err_hit) begin
               state_nxt = ST_IRQ;
               irq_start = 1'b1;
            end else if (ack_ok && (beat_cnt == LAST_BEAT)) begin
               if ((word_idx + 32'd1) == WPF) begin
                  state_nxt = ST_IRQ;
                  irq_start = 1'b1;
               end else begin
                  state_nxt = ST_WAIT_DATA;
               end
            end
         end
         ST_IRQ: begin
            if (irq_last) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address bookkeeping: frame base, pending next frame, word and beat counters
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         cfg_valid_q  <= 1'b0;
         pending      <= 1'b0;
         pending_addr <= 32'h0;
         base_addr    <= 32'h0;
         word_idx     <= 32'h0;
         beat_cnt     <= 32'h0;
      end else begin
         cfg_valid_q <= cfg_valid;
         if (start_frame) begin
            base_addr <= new_addr ? cfg_addr : pending_addr;
            word_idx  <= 32'h0;
            beat_cnt  <= 32'h0;
            pending   <= 1'b0;
         end else if (new_addr) begin
            pending      <= 1'b1;
            pending_addr <= cfg_addr;
         end
         if (ack_ok) begin
            word_idx <= word_idx + 32'd1;
            beat_cnt <= (beat_cnt == LAST_BEAT) ? 32'h0 : beat_cnt + 32'd1;
         end
      end
   end

   // Sticky bus error flag, cleared when software supplies a new address
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         err_q <= 1'b0;
      end else if (err_hit) begin
         err_q <= 1'b1;
      end else if (new_addr) begin
         err_q <= 1'b0;
      end
   end

   video_in_irq_stretch #(
      .P_IRQ_CYCLES (P_IRQ_CYCLES)
   ) u_irq_stretch (
      .clk   (clk),
      .nRST  (nRST),
      .start (irq_start),
      .irq   (irq),
      .last  (irq_last)
   );

endmodule

// File: tb/tb_video_in_dma.sv
// tb/tb_video_in_dma.sv - directed self-checking bench for video_in_dma
module tb_video_in_dma;

   localparam int P_WIDTH        = 8;
   localparam int P_HEIGHT       = 2;
   localparam int P_PIX_PER_WORD = 4;
   localparam int P_BURST        = 4;
   localparam int P_IRQ_CYCLES   = 3;
   localparam int P_FIFO_AW      = 6;

   logic               clk = 1'b0;
   logic               nRST = 1'b0;
   logic [31:0]        cfg_addr = 32'h0;
   logic               cfg_valid = 1'b0;
   logic [31:0]        fifo_data;
   logic [P_FIFO_AW:0] fifo_level;
   logic               fifo_rd;
   logic               wb_cyc_o, wb_stb_o, wb_we_o;
   logic [3:0]         wb_sel_o;
   logic [31:0]        wb_adr_o, wb_dat_o;
   logic               wb_ack_i = 1'b0;
   logic               wb_err_i = 1'b0;
   logic               irq, busy, err;

   video_in_dma #(
      .P_WIDTH        (P_WIDTH),
      .P_HEIGHT       (P_HEIGHT),
      .P_PIX_PER_WORD (P_PIX_PER_WORD),
      .P_BURST        (P_BURST),
      .P_IRQ_CYCLES   (P_IRQ_CYCLES),
      .P_FIFO_AW      (P_FIFO_AW)
   ) dut (
      .clk        (clk),
      .nRST       (nRST),
      .cfg_addr   (cfg_addr),
      .cfg_valid  (cfg_valid),
      .fifo_data  (fifo_data),
      .fifo_level (fifo_level),
      .fifo_rd    (fifo_rd),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_sel_o   (wb_sel_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_i   (wb_ack_i),
      .wb_err_i   (wb_err_i),
      .irq        (irq),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Show-ahead FIFO model
   logic [31:0] mem [0:63];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign fifo_level = (P_FIFO_AW + 1)'(wr_ptr - rd_ptr);
   assign fifo_data  = mem[rd_ptr[5:0]];

   always @(posedge clk) begin
      if (fifo_rd) rd_ptr <= rd_ptr + 1;
   end

   // Wishbone slave model with programmable ack delay and one-shot error injection
   int ack_delay = 0;
   int wait_cnt = 0;
   int ack_total = 0;
   int err_total = 0;
   int err_at = -1;
   int err_req = 0;

   always @(posedge clk) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_stb_o && !wb_ack_i && !wb_err_i) begin
         if (wait_cnt >= ack_delay) begin
            wait_cnt <= 0;
            if (ack_total == err_at && err_total < err_req) begin
               wb_err_i  <= 1'b1;
               err_total <= err_total + 1;
            end else begin
               wb_ack_i  <= 1'b1;
               ack_total <= ack_total + 1;
            end
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else if (!wb_stb_o) begin
         wait_cnt <= 0;
      end
   end

   // Bus monitor: transfer log, pop accounting, stability while waiting for ack
   logic [31:0] adr_log [0:63];
   logic [31:0] dat_log [0:63];
   int          log_n = 0;
   int          rd_n = 0;
   int          bad_rd = 0;
   int          cyc_n = 0;
   int          unstable = 0;
   logic        prev_wait = 1'b0;
   logic [31:0] prev_adr = 32'h0;
   logic [31:0] prev_dat = 32'h0;

   always @(posedge clk) begin
      if (wb_stb_o && wb_ack_i) begin
         adr_log[log_n % 64] <= wb_adr_o;
         dat_log[log_n % 64] <= wb_dat_o;
         log_n <= log_n + 1;
      end
      if (fifo_rd) begin
         rd_n <= rd_n + 1;
         if (!(wb_stb_o && wb_ack_i) || fifo_level == '0) bad_rd <= bad_rd + 1;
      end
      if (wb_cyc_o) cyc_n <= cyc_n + 1;
      if (prev_wait && wb_stb_o && (wb_adr_o != prev_adr || wb_dat_o != prev_dat))
         unstable <= unstable + 1;
      prev_wait <= wb_stb_o && !wb_ack_i;
      prev_adr  <= wb_adr_o;
      prev_dat  <= wb_dat_o;
   end

   int n_vec = 0;
   int n_miss = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      mem[wr_ptr % 64] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic pulse_cfg(input logic [31:0] a);
      cfg_addr  = a;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic wait_cyc(input string tag);
      int k = 0;
      while (!wb_cyc_o && k < 200) begin
         tick();
         k++;
      end
      if (!wb_cyc_o) check({tag, "_cyc_timeout"}, 32'(wb_cyc_o), 32'h1);
   endtask

   // Waits for irq, checks busy is low while it is up, returns its length
   task automatic wait_irq(input string tag, output int len);
      int k = 0;
      len = 0;
      while (!irq && k < 400) begin
         tick();
         k++;
      end
      if (!irq) begin
         check({tag, "_irq_timeout"}, 32'(irq), 32'h1);
      end else begin
         check({tag, "_busy_in_irq"}, 32'(busy), 32'h0);
         while (irq && len < 20) begin
            tick();
            len++;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int l0, r0, c0, a0, len;

      // Reset state
      nRST = 1'b0;
      repeat (3) tick();
      check("rst_cyc", 32'(wb_cyc_o), 32'h0);
      check("rst_stb", 32'(wb_stb_o), 32'h0);
      check("rst_we", 32'(wb_we_o), 32'h0);
      check("rst_adr", wb_adr_o, 32'h0);
      check("rst_dat", wb_dat_o, 32'h0);
      check("rst_rd", 32'(fifo_rd), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      nRST = 1'b1;
      tick();

      // Single frame at 0x1000, immediate acks
      ack_delay = 0;
      for (int i = 0; i < 4; i++) push_word(32'hA0A0_0000 + 32'(i));
      l0 = log_n;
      r0 = rd_n;
      pulse_cfg(32'h0000_1000);
      check("f1_busy", 32'(busy), 32'h1);
      wait_irq("f1", len);
      check("f1_irq_len", 32'(len), 32'd3);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("f1_adr%0d", i), adr_log[(l0 + i) % 64], 32'h0000_1000 + 32'(4 * i));
         check($sformatf("f1_dat%0d", i), dat_log[(l0 + i) % 64], 32'hA0A0_0000 + 32'(i));
      end
      check("f1_rd_count", 32'(rd_n - r0), 32'd4);
      check("f1_idle_busy", 32'(busy), 32'h0);
      check("f1_idle_cyc", 32'(wb_cyc_o), 32'h0);
      check("f1_sel", 32'(wb_sel_o), 32'hF);

      // Slow acks: outputs hold until ack, one pop per ack
      ack_delay = 5;
      for (int i = 0; i < 4; i++) push_word(32'hB0B0_0000 + 32'(i));
      l0 = log_n;
      r0 = rd_n;
      a0 = ack_total;
      pulse_cfg(32'h0000_3000);
      wait_irq("slow", len);
      check("slow_adr0", adr_log[l0 % 64], 32'h0000_3000);
      check("slow_adr3", adr_log[(l0 + 3) % 64], 32'h0000_300C);
      check("slow_dat3", dat_log[(l0 + 3) % 64], 32'hB0B0_0003);
      check("slow_stable", 32'(unstable), 32'h0);
      check("slow_rd_vs_ack", 32'(rd_n - r0), 32'(ack_total - a0));
      check("slow_rd_count", 32'(rd_n - r0), 32'd4);

      // Three words below the burst size: no bus cycle until the fourth arrives
      ack_delay = 0;
      for (int i = 0; i < 3; i++) push_word(32'hC0C0_0000 + 32'(i));
      l0 = log_n;
      c0 = cyc_n;
      pulse_cfg(32'h0000_4000);
      repeat (20) tick();
      check("lvl3_no_cyc", 32'(cyc_n - c0), 32'h0);
      check("lvl3_busy", 32'(busy), 32'h1);
      push_word(32'hC0C0_0003);
      wait_irq("lvl4", len);
      check("lvl4_adr0", adr_log[l0 % 64], 32'h0000_4000);
      check("lvl4_dat3", dat_log[(l0 + 3) % 64], 32'hC0C0_0003);

      // New address during a frame is queued and starts the next frame by itself
      for (int i = 0; i < 8; i++) push_word(32'hD0D0_0000 + 32'(i));
      l0 = log_n;
      pulse_cfg(32'h0000_1000);
      wait_cyc("pend");
      pulse_cfg(32'h0000_2000);
      wait_irq("pend_f1", len);
      check("pend_f1_irq_len", 32'(len), 32'd3);
      wait_irq("pend_f2", len);
      check("pend_f2_irq_len", 32'(len), 32'd3);
      check("pend_f1_adr3", adr_log[(l0 + 3) % 64], 32'h0000_100C);
      check("pend_f2_adr0", adr_log[(l0 + 4) % 64], 32'h0000_2000);
      check("pend_f2_adr3", adr_log[(l0 + 7) % 64], 32'h0000_200C);
      check("pend_f2_dat0", dat_log[(l0 + 4) % 64], 32'hD0D0_0004);
      repeat (10) tick();
      check("pend_no_third", 32'(busy), 32'h0);

      // Asynchronous reset in the middle of a burst
      ack_delay = 5;
      for (int i = 0; i < 4; i++) push_word(32'hE0E0_0000 + 32'(i));
      pulse_cfg(32'h0000_5000);
      wait_cyc("arst");
      @(posedge clk);
      #2;
      nRST = 1'b0;
      #1;
      check("arst_cyc", 32'(wb_cyc_o), 32'h0);
      check("arst_stb", 32'(wb_stb_o), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      check("arst_adr", wb_adr_o, 32'h0);
      tick();
      nRST = 1'b1;
      wr_ptr = rd_ptr;
      repeat (5) tick();
      check("arst_stay_idle", 32'(wb_cyc_o), 32'h0);

      // Bus error on the third word of the frame
      ack_delay = 0;
      for (int i = 0; i < 4; i++) push_word(32'hF0F0_0000 + 32'(i));
      l0 = log_n;
      r0 = rd_n;
      err_at = ack_total + 2;
      err_req = err_total + 1;
      pulse_cfg(32'h0000_6000);
      wait_irq("berr", len);
      check("berr_irq_len", 32'(len), 32'd3);
`ifdef VIDEO_IN_DMA_ERR_EN
      check("berr_err", 32'(err), 32'h1);
      check("berr_rd_count", 32'(rd_n - r0), 32'd2);
      check("berr_idle", 32'(busy), 32'h0);
      wr_ptr = rd_ptr;
      pulse_cfg(32'h0000_7000);
      check("berr_clear", 32'(err), 32'h0);
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      tick();
`else
      check("berr_err", 32'(err), 32'h0);
      check("berr_rd_count", 32'(rd_n - r0), 32'd4);
      check("berr_adr3", adr_log[(l0 + 3) % 64], 32'h0000_600C);
`endif
      check("no_bad_rd", 32'(bad_rd), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
